// File: rtl/cpu_pkg.sv
// Shared encodings for the ALU and its request arbiter.
package cpu_pkg;

  localparam int ALU_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10,
    ALU_DIV = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_rr_pick2.sv
// Two-way round-robin select: on a tie the requester not served last wins.
module rr_pick2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic win_o,
  output logic valid_o
);

  assign valid_o = req0_i | req1_i;
  assign win_o   = (req0_i & req1_i) ? ~last_i : req1_i;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one multi-cycle ALU between two requesters: round-robin grant,
// start/done handshake with a bounded wait, and a one-cycle response.
module alu_arbiter
  import cpu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH_DEFAULT,
  parameter int TIMEOUT = 64
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Req0,
  input  logic             Req1,
  input  logic [1:0]       Req0_OP,
  input  logic [1:0]       Req1_OP,
  input  logic [WIDTH-1:0] Req0_A,
  input  logic [WIDTH-1:0] Req0_B,
  input  logic [WIDTH-1:0] Req1_A,
  input  logic [WIDTH-1:0] Req1_B,
  output logic             Grant0,
  output logic             Grant1,
  output logic             Resp0_Valid,
  output logic             Resp1_Valid,
  output logic [WIDTH-1:0] Resp_Result,
  output logic             Resp_Error,
  output logic [1:0]       ALUOP,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic             ALU_Start,
  input  logic [WIDTH-1:0] ALU_Result,
  input  logic             ALU_Done
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             start_q, start_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       resp_v_q, resp_v_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             error_q, error_d;

  logic pick_win;
  logic pick_valid;

  rr_pick2 u_pick (
    .req0_i (Req0),
    .req1_i (Req1),
    .last_i (last_q),
    .win_o  (pick_win),
    .valid_o(pick_valid)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= ARB_IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      timer_q  <= '0;
      start_q  <= 1'b0;
      grant_q  <= '0;
      resp_v_q <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      timer_q  <= timer_d;
      start_q  <= start_d;
      grant_q  <= grant_d;
      resp_v_q <= resp_v_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    timer_d  = timer_q;
    start_d  = start_q;
    result_d = result_q;
    error_d  = error_q;
    grant_d  = '0;
    resp_v_d = '0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          op_d    = pick_win ? Req1_OP : Req0_OP;
          a_d     = pick_win ? Req1_A  : Req0_A;
          b_d     = pick_win ? Req1_B  : Req0_B;
          owner_d = pick_win;
          last_d  = pick_win;
          timer_d = '0;
          grant_d = pick_win ? 2'b10 : 2'b01;
          start_d = 1'b1;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // Done is checked first so a completion on the last allowed cycle is not lost.
        if (ALU_Done) begin
          result_d = ALU_Result;
          error_d  = 1'b0;
          start_d  = 1'b0;
          resp_v_d = owner_q ? 2'b10 : 2'b01;
          state_d  = ARB_RESP;
        end else if (timer_q == TIMER_LAST) begin
          result_d = '0;
          error_d  = 1'b1;
          start_d  = 1'b0;
          resp_v_d = owner_q ? 2'b10 : 2'b01;
          state_d  = ARB_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        start_d = 1'b0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign Grant0      = grant_q[0];
  assign Grant1      = grant_q[1];
  assign Resp0_Valid = resp_v_q[0];
  assign Resp1_Valid = resp_v_q[1];
  assign Resp_Result = result_q;
  assign Resp_Error  = error_q;
  assign ALUOP       = op_q;
  assign ALU_A       = a_q;
  assign ALU_B       = b_q;
  assign ALU_Start   = start_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: behavioural ALU, request queues and a response scoreboard.
module tb_alu_arbiter;
  import cpu_pkg::*;

  localparam int W  = 16;
  localparam int TO = 24;

  logic         Clock = 1'b0;
  logic         Reset_n = 1'b0;
  logic         Req0 = 1'b0, Req1 = 1'b0;
  logic [1:0]   Req0_OP = 2'b00, Req1_OP = 2'b00;
  logic [W-1:0] Req0_A = '0, Req0_B = '0, Req1_A = '0, Req1_B = '0;
  logic         Grant0, Grant1, Resp0_Valid, Resp1_Valid, Resp_Error, ALU_Start;
  logic [W-1:0] Resp_Result, ALU_A, ALU_B;
  logic [1:0]   ALUOP;
  logic [W-1:0] ALU_Result = '0;
  logic         ALU_Done = 1'b0;

  always #5 Clock = ~Clock;

  alu_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .Req0(Req0), .Req1(Req1), .Req0_OP(Req0_OP), .Req1_OP(Req1_OP),
    .Req0_A(Req0_A), .Req0_B(Req0_B), .Req1_A(Req1_A), .Req1_B(Req1_B),
    .Grant0(Grant0), .Grant1(Grant1), .Resp0_Valid(Resp0_Valid), .Resp1_Valid(Resp1_Valid),
    .Resp_Result(Resp_Result), .Resp_Error(Resp_Error),
    .ALUOP(ALUOP), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_Start(ALU_Start),
    .ALU_Result(ALU_Result), .ALU_Done(ALU_Done)
  );

  typedef struct { logic [1:0] op; logic [W-1:0] a; logic [W-1:0] b; } req_t;
  typedef struct { logic [W-1:0] res; logic err; } resp_t;
  typedef struct { int who; logic [W-1:0] res; logic err; } exp_t;

  req_t  pend0_q[$], pend1_q[$];
  exp_t  exp_q[$];
  resp_t obs0_q[$], obs1_q[$];
  int    gnt_q[$];
  int    run_q[$];
  int    rd0 = 0, rd1 = 0;
  int    pass_cnt = 0, total_cnt = 0;

  // ALU model: Done during the alu_lat-th cycle of Start (0 = never finishes).
  int   alu_lat = 1;
  int   alu_cyc = 0;
  logic spurious_done = 1'b0;

  function automatic logic [W-1:0] alu_fn(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a * b;
      default: return (b == '0) ? '1 : a / b;
    endcase
  endfunction

  always @(posedge Clock) begin
    #1;
    if (ALU_Start) alu_cyc = alu_cyc + 1;
    else alu_cyc = 0;
    ALU_Done   = (ALU_Start && alu_lat != 0 && alu_cyc == alu_lat) || spurious_done;
    ALU_Result = ALU_Done ? alu_fn(ALUOP, ALU_A, ALU_B) : 16'hDEAD;
  end

  // Monitor: records responses, grants, Start run lengths and protocol violations.
  resp_t        mon_r;
  int           mon_run = 0;
  int           bad_cnt = 0;
  logic [1:0]   mon_op;
  logic [W-1:0] mon_a, mon_b;

  always @(negedge Clock) begin
    if (Reset_n) begin
      mon_r.res = Resp_Result;
      mon_r.err = Resp_Error;
      if (Resp0_Valid) obs0_q.push_back(mon_r);
      if (Resp1_Valid) obs1_q.push_back(mon_r);
      if (Grant0) gnt_q.push_back(0);
      if (Grant1) gnt_q.push_back(1);
      if ((Resp0_Valid || Resp1_Valid) && ALU_Start) bad_cnt = bad_cnt + 1;
      if ((Grant0 && Grant1) || (Resp0_Valid && Resp1_Valid)) bad_cnt = bad_cnt + 1;
      if (ALU_Start) begin
        if (mon_run == 0) begin
          mon_op = ALUOP; mon_a = ALU_A; mon_b = ALU_B;
        end else if ({ALUOP, ALU_A, ALU_B} !== {mon_op, mon_a, mon_b}) begin
          bad_cnt = bad_cnt + 1;
        end
        mon_run = mon_run + 1;
      end else if (mon_run > 0) begin
        run_q.push_back(mon_run);
        mon_run = 0;
      end
    end else begin
      mon_run = 0;
    end
  end

  task automatic enqueue(input int who, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] res, input logic err);
    req_t r;
    exp_t e;
    r.op = op; r.a = a; r.b = b;
    e.who = who; e.res = res; e.err = err;
    if (who == 0) pend0_q.push_back(r);
    else pend1_q.push_back(r);
    exp_q.push_back(e);
  endtask

  task automatic get_obs(input int who, output resp_t o);
    o.res = 'x;
    o.err = 1'bx;
    if (who == 0) begin
      if (rd0 < obs0_q.size()) begin o = obs0_q[rd0]; rd0++; end
    end else begin
      if (rd1 < obs1_q.size()) begin o = obs1_q[rd1]; rd1++; end
    end
  endtask

  // Requester driver: holds each Req with its operands until the matching Grant is seen.
  task automatic serve(input string tag);
    int n0 = 0, n1 = 0;
    bit ok = 1'b0;
    foreach (exp_q[i]) begin
      if (exp_q[i].who == 0) n0++;
      else n1++;
    end
    for (int c = 0; c < 1000; c++) begin
      Req0 = (pend0_q.size() > 0);
      if (Req0) begin Req0_OP = pend0_q[0].op; Req0_A = pend0_q[0].a; Req0_B = pend0_q[0].b; end
      Req1 = (pend1_q.size() > 0);
      if (Req1) begin Req1_OP = pend1_q[0].op; Req1_A = pend1_q[0].a; Req1_B = pend1_q[0].b; end
      @(negedge Clock); #1;
      if (Grant0 && pend0_q.size() > 0) void'(pend0_q.pop_front());
      if (Grant1 && pend1_q.size() > 0) void'(pend1_q.pop_front());
      if (pend0_q.size() == 0 && pend1_q.size() == 0 &&
          obs0_q.size() - rd0 >= n0 && obs1_q.size() - rd1 >= n1) begin
        ok = 1'b1;
        break;
      end
    end
    Req0 = 1'b0;
    Req1 = 1'b0;
    if (!ok) begin
      total_cnt++;
      $display("FAIL %s_wait: responses missing after 1000 cycles, got %0d/%0d want %0d/%0d",
               tag, obs0_q.size() - rd0, obs1_q.size() - rd1, n0, n1);
    end
  endtask

  task automatic test_reset();
    int n;
    repeat (3) @(negedge Clock);
    total_cnt++;
    if ({Grant0, Grant1, Resp0_Valid, Resp1_Valid, Resp_Error, ALU_Start} !== 6'b0) begin
      $display("FAIL reset_ctrl: got %b want 000000", {Grant0, Grant1, Resp0_Valid, Resp1_Valid, Resp_Error, ALU_Start});
    end else pass_cnt++;
    total_cnt++;
    if ({ALUOP, ALU_A, ALU_B} !== '0) $display("FAIL reset_alu_bus: got op=%0d a=%0h b=%0h want 0", ALUOP, ALU_A, ALU_B);
    else pass_cnt++;
    total_cnt++;
    if (Resp_Result !== '0) $display("FAIL reset_result: got %0h want 0", Resp_Result);
    else pass_cnt++;
    #1 Reset_n = 1'b1;
    // A stray Done while idle must not produce a response or start anything.
    n = obs0_q.size() + obs1_q.size();
    spurious_done = 1'b1;
    repeat (3) @(negedge Clock);
    total_cnt++;
    if (ALU_Start !== 1'b0) $display("FAIL spurious_start: got %b want 0", ALU_Start);
    else pass_cnt++;
    #1 spurious_done = 1'b0;
    repeat (2) @(negedge Clock);
    total_cnt++;
    if (obs0_q.size() + obs1_q.size() !== n) $display("FAIL spurious_resp: got %0d responses want %0d", obs0_q.size() + obs1_q.size(), n);
    else pass_cnt++;
    #1;
  endtask

  task automatic test_tie();
    exp_t e; resp_t o; int g0;
    repeat (2) @(negedge Clock); #1;
    alu_lat = 1;
    g0 = gnt_q.size();
    enqueue(0, ALU_ADD, 16'd1, 16'd2, 16'd3, 1'b0);
    enqueue(1, ALU_MUL, 16'd3, 16'd4, 16'd12, 1'b0);
    serve("tie");
    for (int i = 0; i < 2; i++) begin
      total_cnt++;
      if (g0 + i >= gnt_q.size() || gnt_q[g0 + i] !== i) $display("FAIL tie_grant%0d: got %0d want %0d", i, (g0 + i < gnt_q.size()) ? gnt_q[g0 + i] : -1, i);
      else pass_cnt++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); get_obs(e.who, o); total_cnt++;
      if (o.res !== e.res || o.err !== e.err) $display("FAIL tie_resp%0d: got res=%0h err=%b want res=%0h err=%b", e.who, o.res, o.err, e.res, e.err);
      else pass_cnt++;
    end
  endtask

  task automatic test_fair();
    exp_t e; resp_t o; int g0;
    repeat (2) @(negedge Clock); #1;
    alu_lat = 2;
    g0 = gnt_q.size();
    enqueue(0, ALU_ADD, 16'd1,  16'd1, 16'd2,    1'b0);
    enqueue(1, ALU_SUB, 16'd10, 16'd4, 16'd6,    1'b0);
    enqueue(0, ALU_MUL, 16'd5,  16'd5, 16'd25,   1'b0);
    enqueue(1, ALU_DIV, 16'd81, 16'd9, 16'd9,    1'b0);
    enqueue(0, ALU_SUB, 16'd3,  16'd5, 16'hFFFE, 1'b0);
    enqueue(1, ALU_ADD, 16'hFFFF, 16'd2, 16'd1,  1'b0);
    serve("fair");
    total_cnt++;
    if (gnt_q.size() - g0 !== 6) $display("FAIL fair_count: got %0d grants want 6", gnt_q.size() - g0);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      total_cnt++;
      if (g0 + i >= gnt_q.size() || gnt_q[g0 + i] !== i % 2) $display("FAIL fair_grant%0d: got %0d want %0d", i, (g0 + i < gnt_q.size()) ? gnt_q[g0 + i] : -1, i % 2);
      else pass_cnt++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); get_obs(e.who, o); total_cnt++;
      if (o.res !== e.res || o.err !== e.err) $display("FAIL fair_resp%0d: got res=%0h err=%b want res=%0h err=%b", e.who, o.res, o.err, e.res, e.err);
      else pass_cnt++;
    end
  endtask

  task automatic test_single();
    repeat (2) @(negedge Clock); #1;
    alu_lat = 1;
    Req0 = 1'b1; Req0_OP = ALU_ADD; Req0_A = 16'd5; Req0_B = 16'd7;
    @(negedge Clock);
    total_cnt++;
    if ({Grant0, Grant1, ALU_Start} !== 3'b101) $display("FAIL single_grant: got g0g1start=%b want 101", {Grant0, Grant1, ALU_Start});
    else pass_cnt++;
    total_cnt++;
    if ({ALUOP, ALU_A, ALU_B} !== {2'b00, 16'd5, 16'd7}) $display("FAIL single_operands: got op=%0d a=%0d b=%0d want 0 5 7", ALUOP, ALU_A, ALU_B);
    else pass_cnt++;
    #1 Req0 = 1'b0;
    @(negedge Clock);
    total_cnt++;
    if ({Resp0_Valid, Resp1_Valid, Resp_Error, ALU_Start, Grant0} !== 5'b10000) $display("FAIL single_resp_ctrl: got %b want 10000", {Resp0_Valid, Resp1_Valid, Resp_Error, ALU_Start, Grant0});
    else pass_cnt++;
    total_cnt++;
    if (Resp_Result !== 16'd12) $display("FAIL single_result: got %0d want 12", Resp_Result);
    else pass_cnt++;
    @(negedge Clock);
    total_cnt++;
    if (Resp0_Valid !== 1'b0) $display("FAIL single_resp_pulse: got %b want 0", Resp0_Valid);
    else pass_cnt++;
    rd0 = obs0_q.size();
    #1;
  endtask

  task automatic test_div();
    exp_t e; resp_t o; int r0;
    repeat (2) @(negedge Clock); #1;
    alu_lat = 17;
    r0 = run_q.size();
    enqueue(0, ALU_DIV, 16'd100, 16'd7, 16'd14, 1'b0);
    serve("div");
    total_cnt++;
    if (run_q.size() <= r0 || run_q[run_q.size() - 1] !== 17) $display("FAIL div_start_len: got %0d want 17", (run_q.size() > r0) ? run_q[run_q.size() - 1] : -1);
    else pass_cnt++;
    total_cnt++;
    if (bad_cnt !== 0) $display("FAIL protocol: got %0d violations want 0", bad_cnt);
    else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); get_obs(e.who, o); total_cnt++;
      if (o.res !== e.res || o.err !== e.err) $display("FAIL div_resp%0d: got res=%0h err=%b want res=%0h err=%b", e.who, o.res, o.err, e.res, e.err);
      else pass_cnt++;
    end
  endtask

  task automatic test_timeout();
    exp_t e; resp_t o; int r0;
    for (int pass = 0; pass < 3; pass++) begin
      repeat (2) @(negedge Clock); #1;
      r0 = run_q.size();
      if (pass == 0) begin
        alu_lat = 0;
        enqueue(1, ALU_ADD, 16'd9, 16'd9, 16'd0, 1'b1);
      end else if (pass == 1) begin
        alu_lat = TO;
        enqueue(0, ALU_MUL, 16'd7, 16'd8, 16'd56, 1'b0);
      end else begin
        alu_lat = 1;
        enqueue(1, ALU_SUB, 16'd10, 16'd3, 16'd7, 1'b0);
      end
      serve("timeout");
      if (pass < 2) begin
        total_cnt++;
        if (run_q.size() <= r0 || run_q[run_q.size() - 1] !== TO) $display("FAIL timeout_start_len%0d: got %0d want %0d", pass, (run_q.size() > r0) ? run_q[run_q.size() - 1] : -1, TO);
        else pass_cnt++;
      end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); get_obs(e.who, o); total_cnt++;
        if (o.res !== e.res || o.err !== e.err) $display("FAIL timeout_resp%0d_%0d: got res=%0h err=%b want res=%0h err=%b", pass, e.who, o.res, o.err, e.res, e.err);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e; resp_t o; int n, g0;
    repeat (2) @(negedge Clock); #1;
    alu_lat = 0;
    Req0 = 1'b1; Req0_OP = ALU_MUL; Req0_A = 16'd6; Req0_B = 16'd7;
    @(negedge Clock); #1;
    Req0 = 1'b0;
    repeat (3) @(negedge Clock); #1;
    n = obs0_q.size() + obs1_q.size();
    total_cnt++;
    if (ALU_Start !== 1'b1) $display("FAIL arst_busy: got start=%b want 1", ALU_Start);
    else pass_cnt++;
    Reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({Grant0, Grant1, Resp0_Valid, Resp1_Valid, Resp_Error, ALU_Start} !== 6'b0) $display("FAIL arst_ctrl: got %b want 000000", {Grant0, Grant1, Resp0_Valid, Resp1_Valid, Resp_Error, ALU_Start});
    else pass_cnt++;
    total_cnt++;
    if ({ALUOP, ALU_A, ALU_B, Resp_Result} !== '0) $display("FAIL arst_data: got op=%0d a=%0h b=%0h res=%0h want 0", ALUOP, ALU_A, ALU_B, Resp_Result);
    else pass_cnt++;
    repeat (2) @(negedge Clock); #1;
    Reset_n = 1'b1;
    repeat (4) @(negedge Clock);
    total_cnt++;
    if (obs0_q.size() + obs1_q.size() !== n) $display("FAIL arst_no_resp: got %0d responses want %0d", obs0_q.size() + obs1_q.size(), n);
    else pass_cnt++;
    #1;
    alu_lat = 1;
    g0 = gnt_q.size();
    enqueue(0, ALU_ADD, 16'd20, 16'd22, 16'd42, 1'b0);
    enqueue(1, ALU_SUB, 16'd50, 16'd8,  16'd42, 1'b0);
    serve("arst");
    for (int i = 0; i < 2; i++) begin
      total_cnt++;
      if (g0 + i >= gnt_q.size() || gnt_q[g0 + i] !== i) $display("FAIL arst_grant%0d: got %0d want %0d", i, (g0 + i < gnt_q.size()) ? gnt_q[g0 + i] : -1, i);
      else pass_cnt++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); get_obs(e.who, o); total_cnt++;
      if (o.res !== e.res || o.err !== e.err) $display("FAIL arst_resp%0d: got res=%0h err=%b want res=%0h err=%b", e.who, o.res, o.err, e.res, e.err);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_fair();
    test_single();
    test_div();
    test_timeout();
    test_async_reset();
    repeat (2) @(negedge Clock);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
